multdiv: RTL

Iterative signed 32-bit multiply/divide unit. Sits directly downstream of the processor's execute stage: the processor drives operands and a one-cycle start strobe, then stalls until the unit reports a result. It shares the processor clock domain; `processor_clock` feeds `clock`. Multiply uses radix-2 Booth recoding and divide uses non-restoring division, one iteration per cycle, with a fixed latency for both.

---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_ctrl.sv | 49 ++++
 rtl/multdiv.sv | 108 ++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state/op encodings and sizing constants for the multiply/divide unit.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_t;

endpackage

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: IDLE/BUSY/DONE sequencer with the per-iteration counter.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic load,
    output logic last_iter,
    output logic done
);

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Strobes are only honoured outside BUSY, so DONE can start the next op.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        busy      = state == BUSY;
        done      = state == DONE;
        last_iter = busy && cnt == CNT_W'(WIDTH - 1);
        load      = start && !busy;
        if (load) begin
            state_nx = BUSY;
            cnt_nx   = '0;
        end else if (busy) begin
            cnt_nx   = cnt + CNT_W'(1);
            state_nx = last_iter ? DONE : BUSY;
        end else if (done) begin
            state_nx = IDLE;
        end
    end

endmodule

// File: rtl/multdiv.sv
// multdiv: iterative signed multiply (radix-2 Booth) / divide (non-restoring),
// one iteration per clock, fixed WIDTH-cycle latency for both operations.
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    logic busy, load, last_iter, done;

    op_t op;
    logic [WIDTH-1:0] mcand, dvs, quo;
    logic [2*WIDTH:0] prod;
    logic [WIDTH+1:0] rem;
    logic neg, div_zero, div_ovf;

    logic [WIDTH:0]   booth_hi, booth_m, booth_sum;
    logic [2*WIDTH:0] prod_nx;
    logic [WIDTH+1:0] rem_sh, rem_nx;
    logic [WIDTH-1:0] quo_nx, quo_fix, a_mag, b_mag, res_nx;
    logic             mul_exc, exc_nx;

    multdiv_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W($clog2(WIDTH))
    ) u_ctrl (
        .clock    (clock),
        .reset    (reset),
        .start    (ctrl_MULT | ctrl_DIV),
        .busy     (busy),
        .load     (load),
        .last_iter(last_iter),
        .done     (done)
    );

    // Booth step: the add is done one bit wider so a most-negative multiplicand
    // cannot overflow the accumulator before the arithmetic shift.
    // Divide step: remainder is kept two bits wider than the magnitudes so the
    // shifted partial remainder never wraps, even for a 2^(WIDTH-1) divisor.
    always_comb begin
        booth_hi  = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        booth_m   = {mcand[WIDTH-1], mcand};
        booth_sum = (prod[1:0] == 2'b01) ? booth_hi + booth_m :
                    (prod[1:0] == 2'b10) ? booth_hi - booth_m : booth_hi;
        prod_nx   = {booth_sum, prod[WIDTH:1]};
        mul_exc   = !((&prod_nx[2*WIDTH:WIDTH]) || !(|prod_nx[2*WIDTH:WIDTH]));
        rem_sh    = {rem[WIDTH:0], quo[WIDTH-1]};
        rem_nx    = rem[WIDTH+1] ? rem_sh + {2'b00, dvs} : rem_sh - {2'b00, dvs};
        quo_nx    = {quo[WIDTH-2:0], ~rem_nx[WIDTH+1]};
        quo_fix   = div_zero ? '0 : neg ? -quo_nx : quo_nx;
        res_nx    = (op == OP_MUL) ? prod_nx[WIDTH:1] : quo_fix;
        exc_nx    = (op == OP_MUL) ? mul_exc : (div_zero | div_ovf);
        a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op             <= OP_MUL;
            mcand          <= '0;
            prod           <= '0;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else begin
            if (load) begin
                op       <= ctrl_MULT ? OP_MUL : OP_DIV;
                mcand    <= data_operandA;
                prod     <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
                rem      <= '0;
                quo      <= a_mag;
                dvs      <= b_mag;
                neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= data_operandB == '0;
                div_ovf  <= data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB;
            end else if (busy) begin
                if (op == OP_MUL) begin
                    prod <= prod_nx;
                end else begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                end
            end
            if (last_iter) begin
                data_result    <= res_nx;
                data_exception <= exc_nx;
            end
        end
    end

    assign data_resultRDY = done;

endmodule
